sync_up_counter: RTL and testbench

Synchronous, loadable, programmable-modulus up counter: the count-up counterpart to the project's synchronous down counter, sharing its `clock`/`reset`/`out` port shape. The block increments `out` on enabled rising edges and wraps to zero after reaching a runtime terminal value. It flags terminal count, wrap events and overflow so several instances can be cascaded or used as timers in Project 1.

---
 rtl/sync_up_counter_if.sv | 25 ++
 rtl/sync_up_counter.sv | 92 +++++++++
 tb/tb_sync_up_counter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sync_up_counter_if.sv
// Control/status bundle for sync_up_counter.
// The master drives the controls and the slave (the counter) drives the status.
interface sync_up_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, clr, load, load_val, max_val,
    input  out, tc, wrap, ovf
  );

  modport slave (
    input  en, clr, load, load_val, max_val,
    output out, tc, wrap, ovf
  );
endinterface

// File: rtl/sync_up_counter.sv
// Loadable, programmable-modulus up counter with terminal-count, wrap and sticky overflow flags.
// Build macro SYNC_UP_COUNTER_SATURATE_EN selects saturating mode instead of wrapping.
module sync_up_counter #(
  parameter int WIDTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  sync_up_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_COUNT,
    OP_LOAD,
    OP_CLEAR
  } op_e;

  op_e              op;
  logic             at_term;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
`ifndef SYNC_UP_COUNTER_SATURATE_EN
  logic             wrap_q, wrap_d;
`endif

  // At or past the terminal value; an over-range load also counts as terminal.
  assign at_term = (out_q >= bus.max_val);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    op = OP_IDLE;
    if (bus.clr)       op = OP_CLEAR;
    else if (bus.load) op = OP_LOAD;
    else if (bus.en)   op = OP_COUNT;
  end

  always_comb begin
    out_d  = out_q;
    ovf_d  = ovf_q;
`ifndef SYNC_UP_COUNTER_SATURATE_EN
    wrap_d = 1'b0;
`endif
    case (op)
      OP_CLEAR: begin
        out_d = '0;
        ovf_d = 1'b0;
      end
      OP_LOAD: out_d = bus.load_val;
      OP_COUNT: begin
        if (at_term) begin
          ovf_d  = 1'b1;
`ifdef SYNC_UP_COUNTER_SATURATE_EN
          out_d  = bus.max_val;
`else
          out_d  = '0;
          wrap_d = 1'b1;
`endif
        end else begin
          out_d = out_q + WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef SYNC_UP_COUNTER_SATURATE_EN
  assign bus.wrap = 1'b0;
`else
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) wrap_q <= 1'b0;
    else        wrap_q <= wrap_d;
  end

  assign bus.wrap = wrap_q;
`endif

  assign bus.out = out_q;
  assign bus.ovf = ovf_q;
  assign bus.tc  = at_term;

endmodule

// File: tb/tb_sync_up_counter.sv
// Self-checking bench for sync_up_counter: directed scenarios plus a randomized run
// compared against an arithmetic reference model.
module tb_sync_up_counter;
  localparam int W = 4;
`ifdef SYNC_UP_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;

  sync_up_counter_if #(.WIDTH(W)) bus ();

  sync_up_counter #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_out;
  bit m_wrap;
  bit m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out  = 0;
    m_wrap = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // Next-state of the counter from the rules: clear, then load, then count.
  task automatic model_edge(input bit e, input bit c, input bit l, input int lv);
    int mx;
    mx     = int'(bus.max_val);
    m_wrap = 1'b0;
    if (c) begin
      m_out = 0;
      m_ovf = 1'b0;
    end else if (l) begin
      m_out = lv;
    end else if (e) begin
      if (m_out >= mx) begin
        m_ovf = 1'b1;
        if (SAT) m_out = mx;
        else begin
          m_out  = 0;
          m_wrap = 1'b1;
        end
      end else begin
        m_out = m_out + 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out"},  bus.out,  m_out);
    check({tag, ".wrap"}, bus.wrap, m_wrap);
    check({tag, ".ovf"},  bus.ovf,  m_ovf);
    check({tag, ".tc"},   bus.tc,   (m_out >= int'(bus.max_val)) ? 1 : 0);
  endtask

  // Drive controls between edges, take one edge, check 1 time unit later.
  task automatic step(input string tag, input bit e, input bit c, input bit l, input int lv);
    bus.en       = e;
    bus.clr      = c;
    bus.load     = l;
    bus.load_val = W'(lv);
    @(posedge clock);
    model_edge(e, c, l, lv);
    #1;
    check_model(tag);
  endtask

  initial begin
    int wrap_count;

    reset        = 1'b0;
    bus.en       = 1'b0;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.max_val  = '0;
    model_reset();
    #1;
    check("rst.out", bus.out, 0);
    check("rst.wrap", bus.wrap, 0);
    check("rst.ovf", bus.ovf, 0);
    check("rst.tc_max0", bus.tc, 1);
    bus.max_val = 4'd15;
    #1;
    check("rst.tc_max15", bus.tc, 0);
    @(negedge clock);
    reset = 1'b1;

    // Reset mid-count
    for (int i = 0; i < 5; i++) step("count5", 1, 0, 0, 0);
    check("count5.value", bus.out, 5);
    #1 reset = 1'b0;
    #1;
    model_reset();
    check("async_rst.out", bus.out, 0);
    check("async_rst.ovf", bus.ovf, 0);
    check("async_rst.wrap", bus.wrap, 0);
    #1 reset = 1'b1;
    step("post_rst", 1, 0, 0, 0);
    check("post_rst.first", bus.out, 1);

    // Modulus wrap at 9
    step("mod.clr", 0, 1, 0, 0);
    bus.max_val = 4'd9;
    for (int i = 0; i < 12; i++) begin
      step("mod", 1, 0, 0, 0);
      check("mod.seq", bus.out, SAT ? ((i + 1 > 9) ? 9 : i + 1) : (i + 1) % 10);
      check("mod.ovf_seq", bus.ovf, (i >= 9) ? 1 : 0);
    end

    // Over-range load
    bus.max_val = 4'd3;
    step("ovr.load", 0, 0, 1, 12);
    check("ovr.loaded", bus.out, 12);
    step("ovr.en", 1, 0, 0, 0);
    check("ovr.out", bus.out, SAT ? 3 : 0);
    check("ovr.wrap", bus.wrap, SAT ? 0 : 1);
    check("ovr.ovf", bus.ovf, 1);

    // Priority clr > load > en
    bus.max_val = 4'd15;
    step("pri.all", 1, 1, 1, 7);
    check("pri.all_out", bus.out, 0);
    check("pri.all_ovf", bus.ovf, 0);
    step("pri.load", 0, 0, 1, 7);
    check("pri.load_out", bus.out, 7);
    step("pri.en", 1, 0, 0, 0);
    check("pri.en_out", bus.out, 8);

    // Full range, then max_val = 0
    step("full.clr", 0, 1, 0, 0);
    wrap_count = 0;
    for (int i = 0; i < 16; i++) begin
      step("full", 1, 0, 0, 0);
      if (bus.wrap === 1'b1) wrap_count++;
    end
    check("full.end_out", bus.out, SAT ? 15 : 0);
    check("full.wraps", wrap_count, SAT ? 0 : 1);
    bus.max_val = 4'd0;
    for (int i = 0; i < 3; i++) begin
      step("max0", 1, 0, 0, 0);
      check("max0.out", bus.out, 0);
      check("max0.wrap", bus.wrap, SAT ? 0 : 1);
    end

    // Enable gating from 2
    bus.max_val = 4'd15;
    step("gate.load", 0, 0, 1, 2);
    step("gate.1", 1, 0, 0, 0);
    check("gate.1v", bus.out, 3);
    step("gate.0", 0, 0, 0, 0);
    check("gate.0v", bus.out, 3);
    step("gate.2", 1, 0, 0, 0);
    check("gate.2v", bus.out, 4);
    step("gate.3", 0, 0, 0, 0);
    check("gate.3v", bus.out, 4);
    check("gate.wrap", bus.wrap, 0);

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) bus.max_val = W'($urandom_range(15));
      step("rand",
           $urandom_range(3) != 0,
           $urandom_range(23) == 0,
           $urandom_range(11) == 0,
           int'($urandom_range(15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
